// File: rtl/chan_emu_cfg_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite config slave between NUM_REQ requesters.
// One single-beat transaction in flight; saturating completed/errored transaction counts.
module chan_emu_cfg_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [2:0]                       m_axi_awprot,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [2:0]                       m_axi_arprot,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             txn_cnt,
  output logic [CNT_WIDTH-1:0]             err_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_RET} state_t;

  state_t                state_q;
  logic [PW-1:0]         ptr_q, win_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic [1:0]            resp_q;
  logic [CNT_WIDTH-1:0]  txn_cnt_q, err_cnt_q;

  logic [PW-1:0]         rot_idx [NUM_REQ];
  logic                  found_d;
  logic [PW-1:0]         win_d, ptr_d;
  logic [PW:0]           win_inc;

  // Candidate order: ptr, ptr+1, ... wrapping modulo NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [PW:0] sum;
    assign sum         = {1'b0, ptr_q} + (PW+1)'(gi);
    assign rot_idx[gi] = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
  end

  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_d && req_valid[rot_idx[k]]) begin
        found_d = 1'b1;
        win_d   = rot_idx[k];
      end
    end
  end

  assign win_inc = {1'b0, win_d} + (PW+1)'(1);
  assign ptr_d   = (win_inc == (PW+1)'(NUM_REQ)) ? '0 : PW'(win_inc);

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && found_d && !ARESET) req_ready[win_d] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RET) rsp_valid[win_q] = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      txn_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (found_d) begin
          win_q     <= win_d;
          ptr_q     <= ptr_d;
          write_q   <= req_write[win_d];
          addr_q    <= req_addr[win_d*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q   <= req_wdata[win_d*DATA_WIDTH +: DATA_WIDTH];
          wstrb_q   <= req_wstrb[win_d*SW +: SW];
          awvalid_q <= req_write[win_d];
          wvalid_q  <= req_write[win_d];
          arvalid_q <= !req_write[win_d];
          state_q   <= S_ADDR;
        end
        S_ADDR: begin
          if (write_q) begin
            // AW and W complete independently, possibly in the same cycle.
            if (m_axi_awready) awvalid_q <= 1'b0;
            if (m_axi_wready)  wvalid_q  <= 1'b0;
            if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) state_q <= S_RESP;
          end else if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          if (write_q && m_axi_bvalid) begin
            resp_q  <= m_axi_bresp;
            rdata_q <= '0;
            state_q <= S_RET;
          end else if (!write_q && m_axi_rvalid) begin
            resp_q  <= m_axi_rresp;
            rdata_q <= m_axi_rdata;
            state_q <= S_RET;
          end
        end
        S_RET: if (rsp_ready[win_q]) begin
          if (txn_cnt_q != '1) txn_cnt_q <= txn_cnt_q + CNT_WIDTH'(1);
          if (resp_q != 2'b00 && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_bready  = (state_q == S_RESP) && write_q;
  assign m_axi_rready  = (state_q == S_RESP) && !write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign busy          = (state_q != S_IDLE);
  assign txn_cnt       = txn_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_chan_emu_cfg_arbiter.sv
// Directed bench for chan_emu_cfg_arbiter with a small behavioural AXI4-Lite slave
// (4 x 32-bit registers, programmable AW wait and read response code).
module tb_chan_emu_cfg_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_rdy;
  logic [7:0]  req_addr, req_wstrb;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        busy;
  logic [15:0] txn_cnt, err_cnt;

  chan_emu_cfg_arbiter dut (
    .ACLK(clk), .ARESET(srst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .busy(busy), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  // Behavioural slave
  logic [31:0] mem [4];
  int          aw_wait, aw_cnt;
  logic [1:0]  slv_rresp;
  logic        aw_got, w_got;
  logic [3:0]  aw_a;
  logic [31:0] w_d;
  logic        aw_hs, w_hs, aw_have, w_have;
  logic [3:0]  wr_a;
  logic [31:0] wr_d;

  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid;
  assign arready = arvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got || w_hs;
  assign wr_a    = aw_hs ? awaddr : aw_a;
  assign wr_d    = w_hs ? wdata : w_d;

  always @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else begin
      if (aw_hs) aw_cnt <= 0;
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (aw_have && w_have && !bvalid) begin
        mem[wr_a[3:2]] <= wr_d;
        bvalid <= 1'b1; bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; end
        if (w_hs) begin w_got <= 1'b1; w_d <= wdata; end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= mem[araddr[3:2]]; rresp <= slv_rresp;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Requester bookkeeping: grant log, auto-drop of valid after grant, completion count
  logic [1:0] gnt_seen, hold;
  int         gnt_log[$];
  int         n_done;

  always @(posedge clk) gnt_seen <= req_ready;

  always @(posedge clk) begin
    if (!srst && (req_ready != 2'b00)) gnt_log.push_back(req_ready[1] ? 1 : 0);
  end

  always @(posedge clk) begin
    if (srst) n_done <= 0;
    else for (int i = 0; i < 2; i++) if (rsp_valid[i] && rsp_rdy[i]) begin
      n_done <= n_done + 1;
      $display("txn req=%0d resp=%0d rdata=0x%08h t=%0t", i, rsp_resp, rsp_rdata, $time);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (gnt_seen[i] && !hold[i]) req_valid[i] = 1'b0;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [3:0] a, input logic [31:0] d);
    req_write[i]          = w;
    req_addr[i*4 +: 4]    = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]   = 4'hF;
    req_valid[i]          = 1'b1;
  endtask

  task automatic wait_rsp(input int i, input string tag, output logic [31:0] rd, output logic [1:0] rp);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (rsp_valid[i]) break;
      n++;
    end
    chk({tag, "_rsp_seen"}, 64'(rsp_valid[i]), 64'd1);
    rd = rsp_rdata;
    rp = rsp_resp;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rp;
    int n_aw, n_w, n_br, n_bad, n_rsp, bad;

    srst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_rdy = 2'b11; hold = '0; aw_wait = 0; slv_rresp = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cnts", {txn_cnt, err_cnt}, 0);
    chk("rst_axi_valid", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_prot", {awprot, arprot}, 0);
    srst = 1'b0;

    // 1: zero-wait write, latency profile
    @(negedge clk);
    issue(0, 1'b1, 4'h4, 32'h2);
    #1 chk("t1_gnt", 64'(req_ready), 64'b01);
    chk("t1_aw_c0", 64'(awvalid), 0);
    @(negedge clk);
    chk("t1_awwv_c1", {awvalid, wvalid}, 64'b11);
    chk("t1_awaddr", 64'(awaddr), 64'h4);
    chk("t1_wdata", 64'(wdata), 64'h2);
    @(negedge clk);
    chk("t1_bready_c2", 64'(bready), 1);
    chk("t1_rsp_c2", 64'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_rsp_c3", 64'(rsp_valid), 64'b01);
    chk("t1_resp_rdata", {rsp_resp, rsp_rdata}, 0);
    @(negedge clk);
    chk("t1_txn", 64'(txn_cnt), 1);
    chk("t1_busy", 64'(busy), 0);

    // 2: ptr moves to 0 via a req1 read, then simultaneous requests and alternation
    issue(1, 1'b0, 4'h4, 32'h0);
    wait_rsp(1, "t2pre", rd, rp);
    chk("t2pre_rdata", 64'(rd), 64'h2);
    @(negedge clk);
    issue(0, 1'b1, 4'h0, 32'h11);
    issue(1, 1'b0, 4'h0, 32'h0);
    #1 chk("t2_gnt_first", 64'(req_ready), 64'b01);
    wait_rsp(0, "t2_w0", rd, rp);
    chk("t2_w0_resp", 64'(rp), 0);
    wait_rsp(1, "t2_r1", rd, rp);
    chk("t2_r1_rdata", 64'(rd), 64'h11);
    @(negedge clk);
    gnt_log.delete();
    hold = 2'b11;
    issue(0, 1'b1, 4'h0, 32'h11);
    issue(1, 1'b0, 4'h0, 32'h0);
    repeat (30) @(negedge clk);
    req_valid = '0;
    hold = '0;
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    chk("t2_idle", 64'(busy), 0);
    chk("t2_ngrants", 64'(gnt_log.size() >= 6), 1);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++)
      chk($sformatf("t2_alt%0d", k), 64'(gnt_log[k]), 64'(k % 2));

    // 3: AW accepted after 5 cycles of awvalid, W immediately
    @(negedge clk);
    aw_wait = 4;
    issue(0, 1'b1, 4'hC, 32'hA5A5_0003);
    n_aw = 0; n_w = 0; n_br = 0; n_bad = 0; n_rsp = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_aw  += int'(awvalid);
      n_w   += int'(wvalid);
      n_br  += int'(bready);
      n_bad += int'(bready && awvalid);
      n_rsp += int'(rsp_valid[0]);
    end
    aw_wait = 0;
    chk("t3_aw_cycles", 64'(n_aw), 5);
    chk("t3_w_cycles", 64'(n_w), 1);
    chk("t3_bready_cycles", 64'(n_br), 1);
    chk("t3_bready_early", 64'(n_bad), 0);
    chk("t3_rsp_count", 64'(n_rsp), 1);

    // 4: read error response
    slv_rresp = 2'b10;
    issue(0, 1'b0, 4'h8, 32'h0);
    wait_rsp(0, "t4", rd, rp);
    slv_rresp = 2'b00;
    chk("t4_resp", 64'(rp), 64'b10);
    @(negedge clk);
    chk("t4_err_cnt", 64'(err_cnt), 1);
    chk("t4_txn_cnt", 64'(txn_cnt), 64'(n_done));

    // 5: response backpressure on req1 while req0 waits
    rsp_rdy[1] = 1'b0;
    issue(1, 1'b0, 4'h0, 32'h0);
    wait_rsp(1, "t5", rd, rp);
    chk("t5_rdata", 64'(rd), 64'h11);
    issue(0, 1'b1, 4'h4, 32'h3);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h11 || req_ready !== 2'b00) bad++;
    end
    chk("t5_hold", 64'(bad), 0);
    rsp_rdy[1] = 1'b1;
    @(negedge clk);
    #1 chk("t5_gnt0", 64'(req_ready), 64'b01);
    wait_rsp(0, "t5_w0", rd, rp);
    chk("t5_w0_resp", 64'(rp), 0);

    // 6: reset while waiting for B, then req1 alone after reset
    @(negedge clk);
    issue(1, 1'b1, 4'h8, 32'h77);
    repeat (2) @(negedge clk);
    chk("t6_in_resp", 64'(bready), 1);
    srst = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_cnts", {txn_cnt, err_cnt}, 0);
    chk("t6_valids", {rsp_valid, req_ready, awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("t6_rsp_regs", {rsp_resp, rsp_rdata}, 0);
    chk("t6_addr", {awaddr, araddr}, 0);
    srst = 1'b0;
    issue(1, 1'b0, 4'h0, 32'h0);
    #1 chk("t6_gnt1", 64'(req_ready), 64'b10);
    wait_rsp(1, "t6_r1", rd, rp);
    chk("t6_rdata", 64'(rd), 0);
    @(negedge clk);
    chk("t6_txn", 64'(txn_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
